// File: rtl/obi_initiator_if.sv
// OBI request and response channel bundles for a memory initiator.
// On the response channel the receiving side is the "slave" modport.
interface obi_req_if;
  logic        req;
  logic        gnt;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;

  modport master (output req, we, be, addr, wdata, input gnt);
  modport slave  (input req, we, be, addr, wdata, output gnt);
endinterface

interface obi_rsp_if;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output rvalid, rdata);
  modport slave  (input rvalid, rdata);
endinterface

// File: rtl/obi_initiator.sv
// OBI initiator: issues one upstream command at a time onto the bus and returns
// responses in order through a credit-limited response FIFO.
module obi_initiator #(
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_we_i,
  input  logic [31:0]       cmd_addr_i,
  input  logic [3:0]        cmd_be_i,
  input  logic [31:0]       cmd_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [31:0]       rsp_rdata_o,
  output logic              rsp_we_o,
  output logic              err_o,
  obi_req_if.master         mem_req,
  obi_rsp_if.slave          mem_rsp
);

  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  typedef logic [CW-1:0] cnt_t;
  typedef logic [PW-1:0] ptr_t;
  typedef enum logic {IDLE, REQ} state_e;

  // Pointers wrap explicitly because the depth need not be a power of two.
  function automatic ptr_t ptr_inc(input ptr_t p);
    if (p == ptr_t'(MAX_OUTSTANDING - 1)) return '0;
    return p + ptr_t'(1);
  endfunction

  state_e                          state_q, state_d;
  logic                            cmd_we_q, cmd_we_d;
  logic [31:0]                     cmd_addr_q, cmd_addr_d;
  logic [3:0]                      cmd_be_q, cmd_be_d;
  logic [31:0]                     cmd_wdata_q, cmd_wdata_d;
  cnt_t                            count_q, count_d;
  logic                            err_q, err_d;

  logic [MAX_OUTSTANDING-1:0]      we_fifo_q, we_fifo_d;
  ptr_t                            we_wptr_q, we_wptr_d;
  ptr_t                            we_rptr_q, we_rptr_d;
  cnt_t                            we_cnt_q, we_cnt_d;

  logic [MAX_OUTSTANDING-1:0][31:0] rsp_data_q, rsp_data_d;
  logic [MAX_OUTSTANDING-1:0]      rsp_we_q, rsp_we_d;
  ptr_t                            rsp_wptr_q, rsp_wptr_d;
  ptr_t                            rsp_rptr_q, rsp_rptr_d;
  cnt_t                            rsp_cnt_q, rsp_cnt_d;

  logic cmd_ready;
  logic req;
  logic granted;
  logic rsp_push;
  logic rsp_pop;

  always_comb begin
    state_d     = state_q;
    cmd_we_d    = cmd_we_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_be_d    = cmd_be_q;
    cmd_wdata_d = cmd_wdata_q;
    count_d     = count_q;
    err_d       = err_q;
    we_fifo_d   = we_fifo_q;
    we_wptr_d   = we_wptr_q;
    we_rptr_d   = we_rptr_q;
    we_cnt_d    = we_cnt_q;
    rsp_data_d  = rsp_data_q;
    rsp_we_d    = rsp_we_q;
    rsp_wptr_d  = rsp_wptr_q;
    rsp_rptr_d  = rsp_rptr_q;
    rsp_cnt_d   = rsp_cnt_q;
    cmd_ready   = 1'b0;
    req         = 1'b0;
    granted     = 1'b0;

    unique case (state_q)
      IDLE: begin
        cmd_ready = (count_q < cnt_t'(MAX_OUTSTANDING));
        if (cmd_valid_i && cmd_ready) begin
          cmd_we_d    = cmd_we_i;
          cmd_addr_d  = cmd_addr_i;
          cmd_be_d    = cmd_be_i;
          cmd_wdata_d = cmd_wdata_i;
          state_d     = REQ;
        end
      end
      REQ: begin
        req = 1'b1;
        if (mem_req.gnt) begin
          granted = 1'b1;
          state_d = IDLE;
        end
      end
    endcase

    // A response with nothing outstanding is dropped and latched as an error.
    rsp_push = mem_rsp.rvalid && (we_cnt_q != '0);
    rsp_pop  = (rsp_cnt_q != '0) && rsp_ready_i;
    if (mem_rsp.rvalid && (we_cnt_q == '0)) err_d = 1'b1;

    if (granted) begin
      we_fifo_d[we_wptr_q] = cmd_we_q;
      we_wptr_d            = ptr_inc(we_wptr_q);
    end
    if (rsp_push) begin
      we_rptr_d              = ptr_inc(we_rptr_q);
      rsp_data_d[rsp_wptr_q] = mem_rsp.rdata;
      rsp_we_d[rsp_wptr_q]   = we_fifo_q[we_rptr_q];
      rsp_wptr_d             = ptr_inc(rsp_wptr_q);
    end
    if (rsp_pop) rsp_rptr_d = ptr_inc(rsp_rptr_q);

    if (granted && !rsp_push)      we_cnt_d = we_cnt_q + cnt_t'(1);
    else if (!granted && rsp_push) we_cnt_d = we_cnt_q - cnt_t'(1);

    if (rsp_push && !rsp_pop)      rsp_cnt_d = rsp_cnt_q + cnt_t'(1);
    else if (!rsp_push && rsp_pop) rsp_cnt_d = rsp_cnt_q - cnt_t'(1);

    if (granted && !rsp_pop)       count_d = count_q + cnt_t'(1);
    else if (!granted && rsp_pop)  count_d = count_q - cnt_t'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cmd_we_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_be_q    <= '0;
      cmd_wdata_q <= '0;
      count_q     <= '0;
      err_q       <= 1'b0;
      we_fifo_q   <= '0;
      we_wptr_q   <= '0;
      we_rptr_q   <= '0;
      we_cnt_q    <= '0;
      rsp_data_q  <= '0;
      rsp_we_q    <= '0;
      rsp_wptr_q  <= '0;
      rsp_rptr_q  <= '0;
      rsp_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      cmd_we_q    <= cmd_we_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_be_q    <= cmd_be_d;
      cmd_wdata_q <= cmd_wdata_d;
      count_q     <= count_d;
      err_q       <= err_d;
      we_fifo_q   <= we_fifo_d;
      we_wptr_q   <= we_wptr_d;
      we_rptr_q   <= we_rptr_d;
      we_cnt_q    <= we_cnt_d;
      rsp_data_q  <= rsp_data_d;
      rsp_we_q    <= rsp_we_d;
      rsp_wptr_q  <= rsp_wptr_d;
      rsp_rptr_q  <= rsp_rptr_d;
      rsp_cnt_q   <= rsp_cnt_d;
    end
  end

  assign cmd_ready_o   = cmd_ready;
  assign mem_req.req   = req;
  assign mem_req.we    = cmd_we_q;
  assign mem_req.addr  = cmd_addr_q;
  assign mem_req.be    = cmd_be_q;
  assign mem_req.wdata = cmd_wdata_q;
  assign rsp_valid_o   = (rsp_cnt_q != '0);
  assign rsp_rdata_o   = rsp_data_q[rsp_rptr_q];
  assign rsp_we_o      = rsp_we_q[rsp_rptr_q];
  assign err_o         = err_q;

endmodule

// File: tb/tb_obi_initiator.sv
// Directed bench for obi_initiator: a queue-based transaction model checked every
// cycle, plus literal expectations at the interesting points of each scenario.
module tb_obi_initiator;
  localparam int unsigned MAX = 2;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        cmd_valid_i, cmd_ready_o, cmd_we_i;
  logic [31:0] cmd_addr_i, cmd_wdata_i;
  logic [3:0]  cmd_be_i;
  logic        rsp_valid_o, rsp_ready_i, rsp_we_o, err_o;
  logic [31:0] rsp_rdata_o;

  obi_req_if mem_req_bus ();
  obi_rsp_if mem_rsp_bus ();

  obi_initiator #(.MAX_OUTSTANDING(MAX)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_addr_i(cmd_addr_i), .cmd_be_i(cmd_be_i), .cmd_wdata_i(cmd_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
    .rsp_we_o(rsp_we_o), .err_o(err_o),
    .mem_req(mem_req_bus.master), .mem_rsp(mem_rsp_bus.slave)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct { logic [31:0] data; logic we; } rsp_t;

  // Model: a command held for issue, the we of granted-not-answered
  // transactions, and the responses waiting for the consumer.
  bit          m_busy  = 1'b0;
  logic        m_we    = 1'b0;
  logic [31:0] m_addr  = '0;
  logic [3:0]  m_be    = '0;
  logic [31:0] m_wdata = '0;
  bit          m_err   = 1'b0;
  bit          m_inflight[$];
  rsp_t        m_rspq[$];

  function automatic bit m_ready();
    return !m_busy && ((m_inflight.size() + m_rspq.size()) < MAX);
  endfunction

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_busy = 1'b0; m_we = 1'b0; m_addr = '0; m_be = '0; m_wdata = '0;
      m_err = 1'b0; m_inflight.delete(); m_rspq.delete();
    end else begin
      bit accept;
      bit pop;
      accept = m_ready() && cmd_valid_i;
      pop    = (m_rspq.size() != 0) && rsp_ready_i;
      if (pop) void'(m_rspq.pop_front());
      if (mem_rsp_bus.rvalid) begin
        if (m_inflight.size() != 0) begin
          rsp_t r;
          r.data = mem_rsp_bus.rdata;
          r.we   = m_inflight.pop_front();
          m_rspq.push_back(r);
        end else begin
          m_err = 1'b1;
        end
      end
      if (m_busy && mem_req_bus.gnt) begin
        m_inflight.push_back(m_we);
        m_busy = 1'b0;
      end else if (accept) begin
        m_busy = 1'b1; m_we = cmd_we_i; m_addr = cmd_addr_i;
        m_be = cmd_be_i; m_wdata = cmd_wdata_i;
      end
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk_i) begin
    check_output("model cmd_ready", 32'(cmd_ready_o), 32'(m_ready()));
    check_output("model req", 32'(mem_req_bus.req), 32'(m_busy));
    if (m_busy) begin
      check_output("model addr", mem_req_bus.addr, m_addr);
      check_output("model we", 32'(mem_req_bus.we), 32'(m_we));
      check_output("model be", 32'(mem_req_bus.be), 32'(m_be));
      check_output("model wdata", mem_req_bus.wdata, m_wdata);
    end
    check_output("model rsp_valid", 32'(rsp_valid_o), 32'(m_rspq.size() != 0));
    if (m_rspq.size() != 0) begin
      check_output("model rsp_rdata", rsp_rdata_o, m_rspq[0].data);
      check_output("model rsp_we", 32'(rsp_we_o), 32'(m_rspq[0].we));
    end
    check_output("model err", 32'(err_o), 32'(m_err));
  end

  task automatic apply_stimulus(input logic cv, input logic we, input logic [31:0] addr,
                                input logic [3:0] be, input logic [31:0] wdata,
                                input logic gnt, input logic rv, input logic [31:0] rdata,
                                input logic rr);
    @(posedge clk_i);
    #1;
    cmd_valid_i = cv; cmd_we_i = we; cmd_addr_i = addr; cmd_be_i = be; cmd_wdata_i = wdata;
    mem_req_bus.gnt = gnt; mem_rsp_bus.rvalid = rv; mem_rsp_bus.rdata = rdata;
    rsp_ready_i = rr;
    @(negedge clk_i);
  endtask

  task automatic slave_cycle(input logic gnt, input logic rv, input logic [31:0] rdata, input logic rr);
    apply_stimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, gnt, rv, rdata, rr);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int req_cycles;
    rst_ni = 1'b0;
    cmd_valid_i = 0; cmd_we_i = 0; cmd_addr_i = 0; cmd_be_i = 0; cmd_wdata_i = 0;
    mem_req_bus.gnt = 0; mem_rsp_bus.rvalid = 0; mem_rsp_bus.rdata = 0; rsp_ready_i = 0;
    repeat (3) @(negedge clk_i);
    check_output("reset cmd_ready", 32'(cmd_ready_o), 32'd1);
    check_output("reset req", 32'(mem_req_bus.req), 32'd0);
    check_output("reset rsp_valid", 32'(rsp_valid_o), 32'd0);
    check_output("reset addr", mem_req_bus.addr, 32'h0);
    rst_ni = 1'b1;

    // Read with immediate gnt and rvalid on the following cycle.
    apply_stimulus(1, 0, 32'h100, 4'hF, 32'h0, 0, 0, 0, 0);
    check_output("read idle req", 32'(mem_req_bus.req), 32'd0);
    slave_cycle(1, 0, 0, 0);
    check_output("read req", 32'(mem_req_bus.req), 32'd1);
    check_output("read addr", mem_req_bus.addr, 32'h100);
    check_output("read cmd_ready in REQ", 32'(cmd_ready_o), 32'd0);
    slave_cycle(0, 1, 32'hDEADBEEF, 0);
    check_output("read rsp not yet", 32'(rsp_valid_o), 32'd0);
    slave_cycle(0, 0, 0, 1);
    check_output("read rsp_valid", 32'(rsp_valid_o), 32'd1);
    check_output("read rdata", rsp_rdata_o, 32'hDEADBEEF);
    check_output("read rsp_we", 32'(rsp_we_o), 32'd0);
    slave_cycle(0, 0, 0, 0);
    check_output("read popped", 32'(rsp_valid_o), 32'd0);

    // Write: bus fields track the command, response flagged as write.
    apply_stimulus(1, 1, 32'h104, 4'b0011, 32'h12345678, 0, 0, 0, 0);
    slave_cycle(1, 0, 0, 0);
    check_output("write we", 32'(mem_req_bus.we), 32'd1);
    check_output("write be", 32'(mem_req_bus.be), 32'h3);
    check_output("write wdata", mem_req_bus.wdata, 32'h12345678);
    slave_cycle(0, 1, 32'hCAFE0001, 0);
    slave_cycle(0, 0, 0, 1);
    check_output("write rsp_we", 32'(rsp_we_o), 32'd1);
    check_output("write rdata", rsp_rdata_o, 32'hCAFE0001);
    slave_cycle(0, 0, 0, 0);

    // Five-cycle grant stall: request held six cycles with stable fields.
    req_cycles = 0;
    apply_stimulus(1, 1, 32'h200, 4'hF, 32'hA5A5A5A5, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      slave_cycle(i == 5, 0, 0, 0);
      if (mem_req_bus.req) req_cycles++;
      check_output("stall addr", mem_req_bus.addr, 32'h200);
      check_output("stall cmd_ready", 32'(cmd_ready_o), 32'd0);
    end
    slave_cycle(0, 1, 32'h55, 0);
    check_output("stall req dropped", 32'(mem_req_bus.req), 32'd0);
    check_output("stall req cycles", 32'(req_cycles), 32'd6);
    slave_cycle(0, 0, 0, 1);
    slave_cycle(0, 0, 0, 0);

    // Credit limit with consumer stalled: third command waits for a pop.
    apply_stimulus(1, 0, 32'h300, 4'hF, 0, 0, 0, 0, 0);
    slave_cycle(1, 0, 0, 0);
    apply_stimulus(1, 0, 32'h304, 4'hF, 0, 0, 0, 0, 0);
    check_output("credit second ready", 32'(cmd_ready_o), 32'd1);
    slave_cycle(1, 0, 0, 0);
    apply_stimulus(1, 0, 32'h308, 4'hF, 0, 0, 1, 32'h0A, 0);
    check_output("credit third blocked", 32'(cmd_ready_o), 32'd0);
    apply_stimulus(1, 0, 32'h308, 4'hF, 0, 0, 1, 32'h0B, 0);
    check_output("credit still blocked", 32'(cmd_ready_o), 32'd0);
    apply_stimulus(1, 0, 32'h308, 4'hF, 0, 0, 0, 0, 1);
    check_output("credit head A", rsp_rdata_o, 32'h0A);
    apply_stimulus(1, 0, 32'h308, 4'hF, 0, 0, 0, 0, 0);
    check_output("credit freed", 32'(cmd_ready_o), 32'd1);
    check_output("credit head B", rsp_rdata_o, 32'h0B);
    slave_cycle(1, 0, 0, 0);
    check_output("credit third addr", mem_req_bus.addr, 32'h308);
    slave_cycle(0, 1, 32'h0C, 1);
    slave_cycle(0, 0, 0, 1);
    check_output("credit head C", rsp_rdata_o, 32'h0C);
    slave_cycle(0, 0, 0, 0);

    // rvalid in the same cycle as a later gnt pairs with the older command.
    apply_stimulus(1, 0, 32'h400, 4'hF, 0, 0, 0, 0, 0);
    slave_cycle(1, 0, 0, 0);
    apply_stimulus(1, 1, 32'h404, 4'hF, 32'h77, 0, 0, 0, 0);
    slave_cycle(1, 1, 32'hD0, 0);
    slave_cycle(0, 1, 32'hE0, 1);
    check_output("pair head D", rsp_rdata_o, 32'hD0);
    check_output("pair D we", 32'(rsp_we_o), 32'd0);
    slave_cycle(0, 0, 0, 1);
    check_output("pair head E", rsp_rdata_o, 32'hE0);
    check_output("pair E we", 32'(rsp_we_o), 32'd1);
    slave_cycle(0, 0, 0, 0);

    // Spurious response with nothing outstanding.
    slave_cycle(0, 1, 32'hBAD, 0);
    slave_cycle(0, 0, 0, 0);
    check_output("spurious err", 32'(err_o), 32'd1);
    check_output("spurious no rsp", 32'(rsp_valid_o), 32'd0);
    slave_cycle(0, 0, 0, 0);
    check_output("spurious err sticky", 32'(err_o), 32'd1);

    // Asynchronous reset while a request is pending.
    apply_stimulus(1, 1, 32'h500, 4'hF, 32'h99, 0, 0, 0, 0);
    slave_cycle(0, 0, 0, 0);
    check_output("prereset req", 32'(mem_req_bus.req), 32'd1);
    #2 rst_ni = 1'b0;
    #1;
    check_output("async reset req", 32'(mem_req_bus.req), 32'd0);
    check_output("async reset cmd_ready", 32'(cmd_ready_o), 32'd1);
    check_output("async reset err", 32'(err_o), 32'd0);
    check_output("async reset addr", mem_req_bus.addr, 32'h0);
    check_output("async reset wdata", mem_req_bus.wdata, 32'h0);
    @(negedge clk_i);
    #1 rst_ni = 1'b1;

    // Normal operation after reset.
    apply_stimulus(1, 0, 32'h600, 4'hF, 0, 0, 0, 0, 0);
    slave_cycle(1, 0, 0, 0);
    check_output("post reset addr", mem_req_bus.addr, 32'h600);
    slave_cycle(0, 1, 32'h600D, 0);
    slave_cycle(0, 0, 0, 1);
    check_output("post reset rdata", rsp_rdata_o, 32'h600D);
    slave_cycle(0, 0, 0, 0);
    check_output("final cmd_ready", 32'(cmd_ready_o), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
